csa_wide_sequencer: RTL and testbench

Multi-cycle wide adder/subtractor controller. It sequences one instance of the team's `carry_skip_adder` over CHUNKS consecutive N-bit slices, so a single narrow carry-skip datapath computes W = N*CHUNKS-bit sums. The inter-chunk carry is held in a register. Requesters use a start/ready/done handshake. It sits between the FPU mantissa/exponent control logic and the shared adder datapath.

---
 rtl/csa_wide_sequencer.sv | 168 ++++++++++++++++
 tb/tb_csa_wide_sequencer.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/csa_wide_sequencer.sv
// rtl/csa_wide_sequencer.sv - multi-cycle W-bit add/sub sequencing one N-bit carry-skip adder over CHUNKS slices
`default_nettype none

module carry_skip_adder #(
    parameter int N = 16,
    parameter int X = 4
) (
    input  logic         CLOCK_50,
    input  logic [N-1:0] A,
    input  logic [N-1:0] B,
    input  logic         Cin,
    output logic [N-1:0] S,
    output logic         Cout
);
    // Purely combinational; the clock pin exists only for datapath pin compatibility.
    logic w_unused_clk;
    assign w_unused_clk = CLOCK_50;

    always_comb begin
        logic w_c;
        logic w_c_blk;
        logic w_rip;
        logic w_p_all;
        logic w_p;
        S       = '0;
        w_c     = Cin;
        w_c_blk = Cin;
        w_rip   = Cin;
        w_p_all = 1'b1;
        w_p     = 1'b0;
        for (int i = 0; i < N; i++) begin
            if ((i % X) == 0) begin
                w_c_blk = w_c;
                w_rip   = w_c;
                w_p_all = 1'b1;
            end
            w_p     = A[i] ^ B[i];
            S[i]    = w_p ^ w_rip;
            w_rip   = (A[i] & B[i]) | (w_p & w_rip);
            w_p_all = w_p_all & w_p;
            // A fully propagating block forwards its incoming carry past the ripple chain.
            if (((i % X) == (X - 1)) || (i == (N - 1))) begin
                w_c = w_p_all ? w_c_blk : w_rip;
            end
        end
        Cout = w_c;
    end
endmodule

module csa_wide_sequencer #(
    parameter int N      = 16,
    parameter int X      = 4,
    parameter int CHUNKS = 4
) (
    input  logic                CLOCK_50,
    input  logic                RESET_N,
    input  logic                start,
    input  logic                sub,
    input  logic                cin,
    input  logic [N*CHUNKS-1:0] A,
    input  logic [N*CHUNKS-1:0] B,
    output logic                ready,
    output logic                done,
    output logic [N*CHUNKS-1:0] S,
    output logic                Cout,
    output logic                Ovf
);
    localparam int W  = N * CHUNKS;
    localparam int KW = (CHUNKS > 1) ? $clog2(CHUNKS) : 1;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    logic [1:0]    r_state;
    logic [KW-1:0] r_k;
    logic          r_carry;
    logic [W-1:0]  r_a;
    logic [W-1:0]  r_bop;
    logic [W-1:0]  r_p;
    logic [W-1:0]  r_s;
    logic          r_cout;
    logic          r_ovf;

    logic [N-1:0]  w_a_slice;
    logic [N-1:0]  w_b_slice;
    logic [N-1:0]  w_sum;
    logic          w_cout;
    logic [W-1:0]  w_p_next;
    logic          w_last;

    always_comb begin
        w_a_slice = '0;
        w_b_slice = '0;
        w_p_next  = r_p;
        for (int c = 0; c < CHUNKS; c++) begin
            if (r_k == KW'(c)) begin
                w_a_slice            = r_a[c*N +: N];
                w_b_slice            = r_bop[c*N +: N];
                w_p_next[c*N +: N]   = w_sum;
            end
        end
    end

    assign w_last = (r_k == KW'(CHUNKS - 1));

    carry_skip_adder #(.N(N), .X(X)) u_adder (
        .CLOCK_50 (CLOCK_50),
        .A        (w_a_slice),
        .B        (w_b_slice),
        .Cin      (r_carry),
        .S        (w_sum),
        .Cout     (w_cout)
    );

    always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
        if (!RESET_N) begin
            r_state <= ST_IDLE;
            r_k     <= '0;
            r_carry <= 1'b0;
            r_a     <= '0;
            r_bop   <= '0;
            r_p     <= '0;
            r_s     <= '0;
            r_cout  <= 1'b0;
            r_ovf   <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_a     <= A;
                        r_bop   <= sub ? ~B : B;
                        r_carry <= sub ? 1'b1 : cin;
                        r_k     <= '0;
                        r_p     <= '0;
                        r_state <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    r_p     <= w_p_next;
                    r_carry <= w_cout;
                    r_k     <= r_k + 1'b1;
                    // Outputs move only here, so partial sums never reach S.
                    if (w_last) begin
                        r_s     <= w_p_next;
                        r_cout  <= w_cout;
                        r_ovf   <= (r_a[W-1] == r_bop[W-1]) && (w_p_next[W-1] != r_a[W-1]);
                        r_state <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign ready = (r_state == ST_IDLE);
    assign done  = (r_state == ST_DONE);
    assign S     = r_s;
    assign Cout  = r_cout;
    assign Ovf   = r_ovf;
endmodule

`default_nettype wire

// File: tb/tb_csa_wide_sequencer.sv
// tb/tb_csa_wide_sequencer.sv - randomized self-checking bench for csa_wide_sequencer
`timescale 1ns/1ps

module tb_csa_wide_sequencer;
    localparam int N = 16;
    localparam int X = 4;
    localparam int CHUNKS = 4;
    localparam int W = N * CHUNKS;

    logic         CLOCK_50 = 1'b0;
    logic         RESET_N;
    logic         start;
    logic         sub;
    logic         cin;
    logic [W-1:0] A;
    logic [W-1:0] B;
    logic         ready;
    logic         done;
    logic [W-1:0] S;
    logic         Cout;
    logic         Ovf;

    int n_checks = 0;
    int n_fail   = 0;

    csa_wide_sequencer #(.N(N), .X(X), .CHUNKS(CHUNKS)) dut (
        .CLOCK_50 (CLOCK_50),
        .RESET_N  (RESET_N),
        .start    (start),
        .sub      (sub),
        .cin      (cin),
        .A        (A),
        .B        (B),
        .ready    (ready),
        .done     (done),
        .S        (S),
        .Cout     (Cout),
        .Ovf      (Ovf)
    );

    always #5 CLOCK_50 = ~CLOCK_50;

    task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Reference: plain wide arithmetic, unsigned compare for borrow, sign rules for overflow.
    function automatic logic [W+1:0] model(input logic [W-1:0] a, input logic [W-1:0] b,
                                           input logic s, input logic c);
        logic [W:0]   sum;
        logic [W-1:0] r;
        logic         co;
        logic         ov;
        if (s) begin
            r  = a - b;
            co = (a >= b);
            ov = (a[W-1] != b[W-1]) && (r[W-1] != a[W-1]);
        end else begin
            sum = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, c};
            r   = sum[W-1:0];
            co  = sum[W];
            ov  = (a[W-1] == b[W-1]) && (r[W-1] != a[W-1]);
        end
        return {co, ov, r};
    endfunction

    function automatic logic [W-1:0] rnd64();
        return {$urandom(), $urandom()};
    endfunction

    task automatic tick();
        @(posedge CLOCK_50);
        #1;
    endtask

    task automatic do_op(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic s, input logic c);
        logic [W+1:0] exp;
        int lat;
        int busy;
        int guard;
        exp = model(a, b, s, c);
        guard = 0;
        while (!ready && guard < 20) begin
            tick();
            guard++;
        end
        check({tag, "_ready_before"}, W'(ready), W'(1));
        A = a; B = b; sub = s; cin = c; start = 1'b1;
        tick();
        start = 1'b0;
        A = rnd64(); B = rnd64(); sub = $urandom_range(0, 1); cin = $urandom_range(0, 1);
        lat = 0;
        busy = 0;
        while (!done && lat < 20) begin
            if (!ready) busy++;
            tick();
            lat++;
        end
        if (!ready) busy++;
        check({tag, "_latency"}, W'(lat), W'(CHUNKS));
        check({tag, "_busy_cycles"}, W'(busy), W'(CHUNKS + 1));
        check({tag, "_S"}, S, exp[W-1:0]);
        check({tag, "_Cout"}, W'(Cout), W'(exp[W+1]));
        check({tag, "_Ovf"}, W'(Ovf), W'(exp[W]));
        tick();
        check({tag, "_done_pulse"}, W'(done), W'(0));
    endtask

    initial begin
        logic [W+1:0] e1;
        logic [W+1:0] e2;
        logic [W-1:0] a1, b1, a2, b2;
        int t;
        int seen;

        RESET_N = 1'b0; start = 1'b0; sub = 1'b0; cin = 1'b0; A = '0; B = '0;
        tick(); tick();
        check("rst_S", S, '0);
        check("rst_Cout", W'(Cout), W'(0));
        check("rst_Ovf", W'(Ovf), W'(0));
        check("rst_done", W'(done), W'(0));
        check("rst_ready", W'(ready), W'(1));
        RESET_N = 1'b1;
        A = rnd64(); B = rnd64();
        tick(); tick(); tick();
        check("idle_ready", W'(ready), W'(1));
        check("idle_done", W'(done), W'(0));
        check("idle_S", S, '0);

        do_op("ripple", 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, 1'b0);
        check("ripple_const", {S[W-2:0], Cout}, 64'd1);
        do_op("sub57", 64'd5, 64'd7, 1'b1, 1'b1);
        check("sub57_const", S, 64'hFFFF_FFFF_FFFF_FFFE);
        do_op("sub75", 64'd7, 64'd5, 1'b1, 1'b0);
        check("sub75_const", S, 64'd2);
        do_op("ovf_add", 64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, 1'b0);
        check("ovf_add_const", S, 64'h8000_0000_0000_0000);
        do_op("ovf_sub", 64'h8000_0000_0000_0000, 64'd1, 1'b1, 1'b0);
        check("ovf_sub_const", S, 64'h7FFF_FFFF_FFFF_FFFF);

        for (int i = 0; i < 24; i++) begin
            logic [W-1:0] ra, rb;
            ra = rnd64();
            rb = rnd64();
            // Bias some runs toward slice-boundary carry chains.
            if (i % 4 == 1) ra = 64'hFFFF_FFFF_FFFF_FFFF ^ (64'h1 << $urandom_range(0, 63));
            if (i % 4 == 2) rb = ~ra;
            do_op("rand", ra, rb, 1'(i % 3 == 0), 1'($urandom_range(0, 1)));
        end

        // Back-to-back with start held and operands changed mid-run
        a1 = rnd64(); b1 = rnd64(); a2 = rnd64(); b2 = rnd64();
        e1 = model(a1, b1, 1'b0, 1'b1);
        e2 = model(a2, b2, 1'b1, 1'b0);
        A = a1; B = b1; sub = 1'b0; cin = 1'b1; start = 1'b1;
        tick();
        tick(); tick();
        A = a2; B = b2; sub = 1'b1; cin = 1'b0;
        t = 0;
        while (!done && t < 20) begin tick(); t++; end
        check("b2b_first_S", S, e1[W-1:0]);
        check("b2b_first_Cout", W'(Cout), W'(e1[W+1]));
        t = 0;
        tick();
        t = 1;
        while (!done && t < 20) begin tick(); t++; end
        start = 1'b0;
        check("b2b_gap", W'(t), W'(CHUNKS + 2));
        check("b2b_second_S", S, e2[W-1:0]);
        check("b2b_second_Ovf", W'(Ovf), W'(e2[W]));
        tick(); tick();

        // Reset after two slices: no done, outputs zeroed at once
        A = 64'h1234_5678_9ABC_DEF0; B = 64'h1111_1111_1111_1111; sub = 1'b0; start = 1'b1;
        tick();
        start = 1'b0;
        tick(); tick();
        #2 RESET_N = 1'b0;
        #1;
        check("mid_rst_ready", W'(ready), W'(1));
        check("mid_rst_done", W'(done), W'(0));
        check("mid_rst_S", S, '0);
        check("mid_rst_Cout", W'(Cout), W'(0));
        tick();
        RESET_N = 1'b1;
        seen = 0;
        for (int i = 0; i < 8; i++) begin
            if (done) seen++;
            tick();
        end
        check("mid_rst_no_done", W'(seen), W'(0));
        do_op("post_rst", 64'h0001_0000_FFFF_0000, 64'h0000_FFFF_0001_0000, 1'b0, 1'b0);
        check("post_rst_const", S, 64'h0002_0000_0000_0000);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout got=running exp=finished");
        $fatal(1, "timeout");
    end
endmodule
